// File: rtl/lcd_dither.sv
// lcd_dither: 4x4 Bayer ordered dither of IN_W-bit RGB down to panel widths, 2-cycle latency.
// Define LCD_DITHER_TEMPORAL_EN to rotate the matrix index over a 4-frame cycle.
module lcd_dither_ch #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 5
) (
    input  logic             clk_pixel,
    input  logic             por,
    input  logic [3:0]       m,
    input  logic             de1,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    localparam int D = IN_W - OUT_W;
    localparam logic [IN_W:0] MAX = (IN_W+1)'((1 << OUT_W) - 1);
    if (D < 0 || D > 4) begin : g_bad_width
        $error("lcd_dither: dropped bits per channel must be 0..4");
    end
    logic [IN_W-1:0] d1;
    logic [3:0]      t1;
    logic [IN_W:0]   sum;
    logic [IN_W:0]   sh;
    assign sum = {1'b0, d1} + (IN_W+1)'(t1);
    assign sh  = sum >> D;
    always_ff @(posedge clk_pixel or posedge por)
        if (por) begin
            d1   <= '0;
            t1   <= '0;
            dout <= '0;
        end else begin
            d1   <= din;
            t1   <= m >> (4 - D);
            dout <= !de1 ? '0 : sh > MAX ? MAX[OUT_W-1:0] : sh[OUT_W-1:0];
        end
endmodule

module lcd_dither #(
    parameter int IN_W    = 6,
    parameter int R_OUT_W = 5,
    parameter int G_OUT_W = 6,
    parameter int B_OUT_W = 5
) (
    input  logic               clk_pixel,
    input  logic               por,
    input  logic               dither_en,
    input  logic               hs_in_n,
    input  logic               vs_in_n,
    input  logic               de_in,
    input  logic [IN_W-1:0]    r_in,
    input  logic [IN_W-1:0]    g_in,
    input  logic [IN_W-1:0]    b_in,
    output logic               hs_out_n,
    output logic               vs_out_n,
    output logic               de_out,
    output logic [R_OUT_W-1:0] r_out,
    output logic [G_OUT_W-1:0] g_out,
    output logic [B_OUT_W-1:0] b_out
);
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };
    logic       de_d, vs_d, hs1, vs1, de1;
    logic       de_rise, de_fall, vs_fall;
    logic [1:0] x_q, y_q, x_cur, xi, yi;
    logic [3:0] m;
    assign de_rise = de_in & ~de_d;
    assign de_fall = ~de_in & de_d;
    assign vs_fall = ~vs_in_n & vs_d;
    assign x_cur   = de_rise ? 2'd0 : x_q;
`ifdef LCD_DITHER_TEMPORAL_EN
    logic [1:0] frame;
    always_ff @(posedge clk_pixel or posedge por)
        if (por) frame <= '0;
        else     frame <= vs_fall ? frame + 2'd1 : frame;
    assign xi = x_cur ^ {frame[0], frame[1]};
    assign yi = y_q ^ {frame[1], frame[0]};
`else
    assign xi = x_cur;
    assign yi = y_q;
`endif
    assign m = dither_en ? BAYER[{yi, xi}] : 4'd0;
    // vsync clear wins over the DE-fall increment when both land together
    always_ff @(posedge clk_pixel or posedge por)
        if (por) begin
            de_d     <= 1'b0;
            vs_d     <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            de1      <= 1'b0;
            hs_out_n <= 1'b1;
            vs_out_n <= 1'b1;
            de_out   <= 1'b0;
        end else begin
            de_d     <= de_in;
            vs_d     <= vs_in_n;
            x_q      <= de_in ? x_cur + 2'd1 : x_q;
            y_q      <= vs_fall ? 2'd0 : de_fall ? y_q + 2'd1 : y_q;
            hs1      <= hs_in_n;
            vs1      <= vs_in_n;
            de1      <= de_in;
            hs_out_n <= hs1;
            vs_out_n <= vs1;
            de_out   <= de1;
        end
    lcd_dither_ch #(.IN_W(IN_W), .OUT_W(R_OUT_W)) u_r (
        .clk_pixel(clk_pixel), .por(por), .m(m), .de1(de1), .din(r_in), .dout(r_out)
    );
    lcd_dither_ch #(.IN_W(IN_W), .OUT_W(G_OUT_W)) u_g (
        .clk_pixel(clk_pixel), .por(por), .m(m), .de1(de1), .din(g_in), .dout(g_out)
    );
    lcd_dither_ch #(.IN_W(IN_W), .OUT_W(B_OUT_W)) u_b (
        .clk_pixel(clk_pixel), .por(por), .m(m), .de1(de1), .din(b_in), .dout(b_out)
    );
endmodule

// File: tb/tb_lcd_dither.sv
// tb_lcd_dither: directed checks of reset, latency, Bayer pattern, saturation, blanking and y-counter priority.
module tb_lcd_dither;
    logic       clk_pixel = 1'b0;
    logic       por = 1'b1;
    logic       dither_en = 1'b0;
    logic       hs_in_n = 1'b1;
    logic       vs_in_n = 1'b1;
    logic       de_in = 1'b0;
    logic [5:0] r_in = '0;
    logic [5:0] g_in = '0;
    logic [5:0] b_in = '0;
    logic       hs_out_n, vs_out_n, de_out;
    logic [4:0] r_out, b_out;
    logic [5:0] g_out;
    int checks = 0;
    int errors = 0;
    int frames = 0;
    logic [4:0] cr[$];
    logic [5:0] cg[$];
    logic [4:0] cb[$];
    logic       chs[$];
    logic       cvs[$];
    logic       cde[$];
    int bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    lcd_dither dut (
        .clk_pixel(clk_pixel), .por(por), .dither_en(dither_en),
        .hs_in_n(hs_in_n), .vs_in_n(vs_in_n), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_out_n(hs_out_n), .vs_out_n(vs_out_n), .de_out(de_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    // capture index k holds the output belonging to the input driven at index k-1
    task automatic cyc(input logic de, input logic hs, input logic vs, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        de_in = de; hs_in_n = hs; vs_in_n = vs; r_in = r; g_in = g; b_in = b;
        @(posedge clk_pixel);
        #1;
        cr.push_back(r_out); cg.push_back(g_out); cb.push_back(b_out);
        chs.push_back(hs_out_n); cvs.push_back(vs_out_n); cde.push_back(de_out);
    endtask

    task automatic clr();
        cr.delete(); cg.delete(); cb.delete(); chs.delete(); cvs.delete(); cde.delete();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic vs_pulse();
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
        idle();
        frames++;
    endtask

    task automatic run_line(input int n, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        clr();
        repeat (n) cyc(1'b1, 1'b1, 1'b1, r, g, b);
        repeat (3) idle();
    endtask

    // red (5-bit) output for r_in=1 at pixel x,y, dithered
    function automatic logic [4:0] exp_r1(input int x, input int y);
        logic [1:0] xi = 2'(x);
        logic [1:0] yi = 2'(y);
`ifdef LCD_DITHER_TEMPORAL_EN
        logic [1:0] f = 2'(frames);
        xi = xi ^ {f[0], f[1]};
        yi = yi ^ {f[1], f[0]};
`endif
        return 5'((1 + (bayer[{28'd0, yi, xi}] >> 3)) >> 1);
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk_pixel);
        #1;
        checks += 6;
        if (hs_out_n !== 1'b1 || vs_out_n !== 1'b1 || de_out !== 1'b0 || r_out !== 5'd0 || g_out !== 6'd0 || b_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_init hs=%b vs=%b de=%b r=%0d g=%0d b=%0d want 1 1 0 0 0 0", hs_out_n, vs_out_n, de_out, r_out, g_out, b_out);
        end
        por = 1'b0;
        dither_en = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 6'd63, 6'd63, 6'd63);
        checks++;
        if (r_out !== 5'd31 || hs_out_n !== 1'b0 || de_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre r=%0d hs=%b de=%b want 31 0 1", r_out, hs_out_n, de_out);
        end
        #3 por = 1'b1;
        #1;
        checks += 6;
        if (hs_out_n !== 1'b1) begin errors++; $display("FAIL reset_hs got %b want 1", hs_out_n); end
        if (vs_out_n !== 1'b1) begin errors++; $display("FAIL reset_vs got %b want 1", vs_out_n); end
        if (de_out !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", de_out); end
        if (r_out !== 5'd0) begin errors++; $display("FAIL reset_r got %0d want 0", r_out); end
        if (g_out !== 6'd0) begin errors++; $display("FAIL reset_g got %0d want 0", g_out); end
        if (b_out !== 5'd0) begin errors++; $display("FAIL reset_b got %0d want 0", b_out); end
        de_in = 1'b0; hs_in_n = 1'b1; vs_in_n = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1 por = 1'b0;
        frames = 0;
        idle();
        dither_en = 1'b1;
        run_line(4, 6'd1, 6'd1, 6'd1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cr[k+1] !== exp_r1(k, 0)) begin
                errors++;
                $display("FAIL reset_first_line x%0d got %0d want %0d", k, cr[k+1], exp_r1(k, 0));
            end
        end
    endtask

    task automatic test_latency();
        dither_en = 1'b0;
        clr();
        idle();
        cyc(1'b1, 1'b0, 1'b1, 6'd20, 6'd0, 6'd0);
        repeat (3) idle();
        checks += 6;
        if (chs[1] !== 1'b1) begin errors++; $display("FAIL latency_hs_early got %b want 1", chs[1]); end
        if (chs[2] !== 1'b0) begin errors++; $display("FAIL latency_hs got %b want 0", chs[2]); end
        if (chs[3] !== 1'b1) begin errors++; $display("FAIL latency_hs_late got %b want 1", chs[3]); end
        if (cde[2] !== 1'b1) begin errors++; $display("FAIL latency_de got %b want 1", cde[2]); end
        if (cde[3] !== 1'b0) begin errors++; $display("FAIL latency_de_late got %b want 0", cde[3]); end
        if (cr[2] !== 5'd10) begin errors++; $display("FAIL latency_r got %0d want 10", cr[2]); end
    endtask

    task automatic test_pattern();
        clr();
        vs_pulse();
        idle();
        checks += 3;
        if (cvs[0] !== 1'b1) begin errors++; $display("FAIL vs_latency_early got %b want 1", cvs[0]); end
        if (cvs[1] !== 1'b0) begin errors++; $display("FAIL vs_latency got %b want 0", cvs[1]); end
        if (cvs[2] !== 1'b1) begin errors++; $display("FAIL vs_latency_late got %b want 1", cvs[2]); end
        dither_en = 1'b1;
        // line y=1 is 3 pixels wide so the next line must restart x at 0
        for (int l = 0; l < 5; l++) begin
            int n = (l == 1) ? 3 : 4;
            run_line(n, 6'd1, 6'd2, 6'd1);
            for (int k = 0; k < n; k++) begin
                checks += 3;
                if (cr[k+1] !== exp_r1(k, l % 4)) begin
                    errors++;
                    $display("FAIL pattern_r y%0d x%0d got %0d want %0d", l % 4, k, cr[k+1], exp_r1(k, l % 4));
                end
                if (cb[k+1] !== exp_r1(k, l % 4)) begin
                    errors++;
                    $display("FAIL pattern_b y%0d x%0d got %0d want %0d", l % 4, k, cb[k+1], exp_r1(k, l % 4));
                end
                if (cg[k+1] !== 6'd2) begin
                    errors++;
                    $display("FAIL pattern_g y%0d x%0d got %0d want 2", l % 4, k, cg[k+1]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        vs_pulse();
        dither_en = 1'b1;
        run_line(4, 6'd63, 6'd63, 6'd63);
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (cr[k+1] !== 5'd31) begin errors++; $display("FAIL sat_r x%0d got %0d want 31", k, cr[k+1]); end
            if (cg[k+1] !== 6'd63) begin errors++; $display("FAIL sat_g x%0d got %0d want 63", k, cg[k+1]); end
            if (cb[k+1] !== 5'd31) begin errors++; $display("FAIL sat_b x%0d got %0d want 31", k, cb[k+1]); end
        end
    endtask

    task automatic test_y_priority();
        vs_pulse();
        dither_en = 1'b1;
        for (int l = 0; l < 2; l++) begin
            run_line(1, 6'd1, 6'd1, 6'd1);
            checks++;
            if (cr[1] !== exp_r1(0, l)) begin
                errors++;
                $display("FAIL one_pixel_line y%0d got %0d want %0d", l, cr[1], exp_r1(0, l));
            end
        end
        clr();
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 6'd1, 6'd1, 6'd1);
        cyc(1'b0, 1'b1, 1'b0, 6'd63, 6'd63, 6'd63);
        frames++;
        repeat (2) idle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cr[k+1] !== exp_r1(k, 2)) begin
                errors++;
                $display("FAIL y2_line x%0d got %0d want %0d", k, cr[k+1], exp_r1(k, 2));
            end
        end
        checks += 4;
        if (cde[5] !== 1'b0 || cvs[5] !== 1'b0) begin errors++; $display("FAIL blank_sync de=%b vs=%b want 0 0", cde[5], cvs[5]); end
        if (cr[5] !== 5'd0) begin errors++; $display("FAIL blank_r got %0d want 0", cr[5]); end
        if (cg[5] !== 6'd0) begin errors++; $display("FAIL blank_g got %0d want 0", cg[5]); end
        if (cb[5] !== 5'd0) begin errors++; $display("FAIL blank_b got %0d want 0", cb[5]); end
        run_line(4, 6'd1, 6'd1, 6'd1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cr[k+1] !== exp_r1(k, 0)) begin
                errors++;
                $display("FAIL y_priority x%0d got %0d want %0d", k, cr[k+1], exp_r1(k, 0));
            end
        end
    endtask

`ifdef LCD_DITHER_TEMPORAL_EN
    task automatic test_temporal();
        logic [4:0] want [4] = '{5'd0, 5'd1, 5'd1, 5'd0};
        dither_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vs_pulse();
            run_line(1, 6'd1, 6'd1, 6'd1);
            checks++;
            if (cr[1] !== want[frames % 4]) begin
                errors++;
                $display("FAIL temporal frame%0d got %0d want %0d", frames % 4, cr[1], want[frames % 4]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_pattern();
        test_saturation();
        test_y_priority();
`ifdef LCD_DITHER_TEMPORAL_EN
        test_temporal();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
